// File: rtl/display_pkg.sv
// Shared types and 7-segment constants for the result display.
// Segment order {g,f,e,d,c,b,a}, active low.
package display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] seg_decode(
    input bcd_t d
  );
    logic [6:0] s;
    s = SEG_OFF;
    unique case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/module_bin_to_bcd.sv
// Sequential double-dabble: load/bin_in in, busy/done/bcd out.
// bcd only changes on the COMMIT->IDLE edge, together with done.
module module_bin_to_bcd
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bin_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state;
  conv_state_t state_nx;

  logic [7:0]  shift_reg;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [2:0]  iter;

  function automatic bcd_t add3(
    input bcd_t n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign adj = {add3(scratch[11:8]),
                add3(scratch[7:4]),
                add3(scratch[3:0])};

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (iter == 3'd7) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            iter      <= '0;
          end
        end
        ST_SHIFT: begin
          {scratch, shift_reg} <=
            {adj[10:0], shift_reg, 1'b0};
          iter <= iter + 3'd1;
        end
        ST_COMMIT: begin
          bcd  <= scratch;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/module_display_resultado.sv
// Captures a selector value, converts it to BCD and scans it onto
// a 4-digit common-anode display (seg/an active low, an[0]=units).
module module_display_resultado
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 27_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bin_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;

  bcd_t hund;
  bcd_t tens;
  bcd_t units;

  module_bin_to_bcd u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .bin_in (bin_in),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  assign hund  = bcd[11:8];
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST)
                   ? 2'd0 : digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Leading zeros blank; the fourth digit is always dark.
  always_comb begin
    seg = SEG_OFF;
    an  = 4'b1111;
    unique case (1'b1)
      (digit_idx == 2'd0): begin
        an  = 4'b1110;
        seg = seg_decode(units);
      end
      (digit_idx == 2'd1): begin
        an  = 4'b1101;
        if (hund != 4'd0 || tens != 4'd0)
          seg = seg_decode(tens);
      end
      (digit_idx == 2'd2): begin
        an  = 4'b1011;
        if (hund != 4'd0)
          seg = seg_decode(hund);
      end
      default: begin
        an  = 4'b0111;
        seg = SEG_OFF;
      end
    endcase
  end

endmodule
